// File: rtl/axi4_pkg.sv
// Shared definitions for the AXI4 burst master: FSM state encoding,
// response encoding and the retry limit used when AXI4M_RETRY_EN is defined.
package axi4_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } axi4_state_e;

  // Response bit: 1 = OK, 0 = error.
  localparam logic RESP_OK   = 1'b1;
  localparam int   MAX_RETRY = 3;

endpackage

// File: rtl/axi4_beat_ctr.sv
// Beat counter for one burst: counts accepted beats modulo N and flags the
// final beat so the owning FSM can drive/check the last indication.
module axi4_beat_ctr
  import axi4_pkg::*;
#(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         _rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);

  assign last = (int'(cnt) == N - 1);

  // Advance on each accepted beat, wrapping back to zero after the last one.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axi4_burst_master.sv
// AXI4 burst master: writes NOPS operands as SZ/DSZ-beat bursts to addresses
// 0..NOPS-1, then reads a 2*SZ-bit result burst from RES_ADDR.
// Optional macro AXI4M_RETRY_EN: reissue a burst that got an error response,
// up to MAX_RETRY times, before flagging err.
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid & ready are both high; a raised valid stays high with a stable payload
// until that edge.
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter int NOPS     = 2,
  parameter int SZ       = 32,
  parameter int DSZ      = 8,
  parameter int ASZ      = 2,
  parameter int RES_ADDR = NOPS
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              start,
  input  logic [NOPS*SZ-1:0] ops,
  output logic              busy,
  output logic [2*SZ-1:0]   res,
  output logic              done,
  output logic              err,
  output logic [ASZ-1:0]    awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DSZ-1:0]    wdata,
  output logic              wvalid,
  input  logic              wready,
  output logic              wlast,
  input  logic              bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ASZ-1:0]    araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DSZ-1:0]    rdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic              rlast,
  input  logic              rresp,
  output axi4_state_e       dbg_state
);

  localparam int BEATS  = SZ / DSZ;
  localparam int RBEATS = 2 * BEATS;
  localparam int WCW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RCW    = $clog2(RBEATS);
  localparam int IW     = (NOPS > 1) ? $clog2(NOPS) : 1;

  axi4_state_e          state;
  logic [NOPS*SZ-1:0]   ops_q;
  logic [IW-1:0]        idx;
  logic [2*SZ-1:0]      res_acc;
  logic [2*SZ-1:0]      res_nxt;
  logic [SZ-1:0]        cur_op;
  logic [DSZ-1:0]       nxt_beat;
  logic [WCW-1:0]       w_cnt;
  logic                 w_last;
  logic [RCW-1:0]       r_cnt;
  logic                 r_last;
  logic                 w_hs;
  logic                 r_hs;
  logic                 b_retry;
  logic                 r_retry;
`ifdef AXI4M_RETRY_EN
  logic [1:0]           retry;
  logic                 rbad_q;
`endif

  assign dbg_state = state;
  assign w_hs      = wvalid & wready;
  assign r_hs      = (state == S_R) & rvalid & rready;

  axi4_beat_ctr #(.N(BEATS), .W(WCW)) u_w_ctr (
    .clk  (clk),
    ._rst (_rst),
    .clr  (state == S_IDLE),
    .inc  (w_hs),
    .cnt  (w_cnt),
    .last (w_last)
  );

  axi4_beat_ctr #(.N(RBEATS), .W(RCW)) u_r_ctr (
    .clk  (clk),
    ._rst (_rst),
    .clr  (state == S_IDLE),
    .inc  (r_hs),
    .cnt  (r_cnt),
    .last (r_last)
  );

  // Operand/beat selection, result merge and retry decisions.
  always_comb begin
    int nb;
    cur_op   = ops_q[int'(idx)*SZ +: SZ];
    nb       = w_last ? 0 : int'(w_cnt) + 1;
    nxt_beat = cur_op[nb*DSZ +: DSZ];
    res_nxt  = res_acc;
    res_nxt[int'(r_cnt)*DSZ +: DSZ] = rdata;
    b_retry  = 1'b0;
    r_retry  = 1'b0;
`ifdef AXI4M_RETRY_EN
    b_retry  = (bresp != RESP_OK) && (int'(retry) < MAX_RETRY);
    r_retry  = (rbad_q || (rresp != RESP_OK)) && (int'(retry) < MAX_RETRY);
`endif
  end

  // Transaction FSM with registered channel outputs.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state   <= S_IDLE;
      ops_q   <= '0;
      idx     <= '0;
      res_acc <= '0;
      res     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      awaddr  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wvalid  <= 1'b0;
      wlast   <= 1'b0;
      bready  <= 1'b0;
      araddr  <= '0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
`ifdef AXI4M_RETRY_EN
      retry   <= '0;
      rbad_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ops_q   <= ops;
            idx     <= '0;
            busy    <= 1'b1;
            err     <= 1'b0;
            awaddr  <= '0;
            awvalid <= 1'b1;
            state   <= S_AW;
`ifdef AXI4M_RETRY_EN
            retry   <= '0;
`endif
          end
        end
        S_AW: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wdata   <= cur_op[DSZ-1:0];
            wlast   <= (BEATS == 1);
            state   <= S_W;
          end
        end
        S_W: begin
          if (w_hs) begin
            if (w_last) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              state  <= S_B;
            end else begin
              wdata <= nxt_beat;
              wlast <= (int'(w_cnt) + 2 == BEATS);
            end
          end
        end
        S_B: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (b_retry) begin
`ifdef AXI4M_RETRY_EN
              retry <= retry + 2'd1;
`endif
              awvalid <= 1'b1;
              state   <= S_AW;
            end else begin
              if (bresp != RESP_OK) err <= 1'b1;
`ifdef AXI4M_RETRY_EN
              retry <= '0;
`endif
              if (int'(idx) < NOPS - 1) begin
                idx     <= idx + 1'b1;
                awaddr  <= ASZ'(int'(idx) + 1);
                awvalid <= 1'b1;
                state   <= S_AW;
              end else begin
                araddr  <= ASZ'(RES_ADDR);
                arvalid <= 1'b1;
                state   <= S_AR;
              end
            end
          end
        end
        S_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
`ifdef AXI4M_RETRY_EN
            rbad_q  <= 1'b0;
`endif
          end
        end
        S_R: begin
          if (r_hs) begin
            res_acc <= res_nxt;
            if (rlast != r_last) err <= 1'b1;
`ifdef AXI4M_RETRY_EN
            rbad_q <= rbad_q | (rresp != RESP_OK);
`else
            if (rresp != RESP_OK) err <= 1'b1;
`endif
            if (r_last) begin
              rready <= 1'b0;
              if (r_retry) begin
`ifdef AXI4M_RETRY_EN
                retry  <= retry + 2'd1;
                rbad_q <= 1'b0;
`endif
                arvalid <= 1'b1;
                state   <= S_AR;
              end else begin
`ifdef AXI4M_RETRY_EN
                if (rbad_q || (rresp != RESP_OK)) err <= 1'b1;
`endif
                res   <= res_nxt;
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
